// File: rtl/riscv_cpu_pkg.sv
// Shared core definitions used by the data-memory arbiter and its ID FIFO.
package riscv_cpu_pkg;

  // Number of requesters sharing the data-memory port.
  localparam int unsigned NUM_DMEM_MASTERS = 2;

  // Native core data-path width carried by the request bundle.
  localparam int unsigned DMEM_XLEN = 32;

  // Master identifiers; the value is also the index into the per-master ports.
  typedef enum logic {
    DMEM_DBG = 1'b0,
    DMEM_LSU = 1'b1
  } dmem_master_e;

  // One master's request fields, bundled so the mux selects a single value.
  typedef struct packed {
    logic [DMEM_XLEN-1:0] addr;
    logic                 we;
    logic [3:0]           be;
    logic [DMEM_XLEN-1:0] wdata;
  } dmem_req_t;

  // Arbiter selection state: free to arbitrate, or held on an ungranted request.
  typedef enum logic {
    ARB_OPEN = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_id_fifo.sv
// Small synchronous FIFO that records the owner of each outstanding
// memory transaction, oldest first.
module dmem_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is not reset; validity is tracked by count alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the debug/DMA
// port (master 0) and the load/store unit (master 1). Responses are routed
// back in order using a FIFO of transaction owners.
//
// state    | meaning
// ARB_OPEN | no pending ungranted request; selection follows round-robin
// ARB_HOLD | a request is waiting for grant; selection pinned to lock_id
module data_mem_arbiter
  import riscv_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [NUM_DMEM_MASTERS-1:0]                 m_req_i,
  output logic [NUM_DMEM_MASTERS-1:0]                 m_gnt_o,
  output logic [NUM_DMEM_MASTERS-1:0]                 m_rvalid_o,
  input  logic [NUM_DMEM_MASTERS-1:0][DATA_WIDTH-1:0] m_addr_i,
  input  logic [NUM_DMEM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_DMEM_MASTERS-1:0][3:0]            m_be_i,
  input  logic [NUM_DMEM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i,
  output logic [DATA_WIDTH-1:0]                       m_rdata_o,
  output logic                                        data_req_o,
  input  logic                                        data_gnt_i,
  input  logic                                        data_rvalid_i,
  output logic [DATA_WIDTH-1:0]                       data_addr_o,
  output logic                                        data_we_o,
  output logic [3:0]                                  data_be_o,
  output logic [DATA_WIDTH-1:0]                       data_wdata_o,
  input  logic [DATA_WIDTH-1:0]                       data_rdata_i,
  output logic                                        err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e   state_q, state_d;
  dmem_master_e lock_id_q, lock_id_d;
  dmem_master_e rr_last_q;
  dmem_master_e sel;
  logic         full;
  logic         handshake;
  logic         pop;
  logic         err_q;
  logic [0:0]   fifo_head;
  logic [CNT_W-1:0] count;

  dmem_req_t [NUM_DMEM_MASTERS-1:0] bundle;
  dmem_req_t                        sel_bundle;

  // Pack each master's request fields into the core-width bundle.
  for (genvar i = 0; i < NUM_DMEM_MASTERS; i++) begin : g_bundle
    assign bundle[i].addr  = DMEM_XLEN'(m_addr_i[i]);
    assign bundle[i].we    = m_we_i[i];
    assign bundle[i].be    = m_be_i[i];
    assign bundle[i].wdata = DMEM_XLEN'(m_wdata_i[i]);
  end

  // Issue gating depends only on registered occupancy, so rvalid never
  // reaches data_req_o combinationally.
  assign full = (count == CNT_W'(MAX_OUTSTANDING));

  // Selection, request issue and hold-state transitions.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    sel       = DMEM_DBG;
    if (state_q == ARB_HOLD) begin
      sel = lock_id_q;
    end else if (&m_req_i) begin
      sel = (rr_last_q == DMEM_LSU) ? DMEM_DBG : DMEM_LSU;
    end else if (m_req_i[DMEM_LSU]) begin
      sel = DMEM_LSU;
    end
    data_req_o = m_req_i[sel] & ~full;
    handshake  = data_req_o & data_gnt_i;
    if (data_req_o && !data_gnt_i) begin
      state_d   = ARB_HOLD;
      lock_id_d = sel;
    end else begin
      state_d = ARB_OPEN;
    end
  end

  // Hold state, lock owner, round-robin pointer and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB_OPEN;
      lock_id_q <= DMEM_DBG;
      rr_last_q <= DMEM_LSU;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      if (handshake) begin
        rr_last_q <= sel;
      end
      if (data_rvalid_i && (count == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Grant goes only to the selected master; responses go to the FIFO head.
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_gnt_o[sel]       = handshake;
    m_rvalid_o[fifo_head] = pop;
  end

  assign pop = data_rvalid_i & (count != '0);

  dmem_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (handshake),
    .push_data (sel),
    .pop       (pop),
    .head      (fifo_head),
    .count     (count)
  );

  assign sel_bundle   = bundle[sel];
  assign data_addr_o  = DATA_WIDTH'(sel_bundle.addr);
  assign data_we_o    = sel_bundle.we;
  assign data_be_o    = sel_bundle.be;
  assign data_wdata_o = DATA_WIDTH'(sel_bundle.wdata);
  assign m_rdata_o    = data_rdata_i;
  assign err_o        = err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against an owner-queue reference model.
module tb_data_mem_arbiter;

  localparam int MAXO = 2;

  logic             clk;
  logic             rst;
  logic [1:0]       m_req;
  logic [1:0]       m_gnt;
  logic [1:0]       m_rvalid;
  logic [1:0][31:0] m_addr;
  logic [1:0]       m_we;
  logic [1:0][3:0]  m_be;
  logic [1:0][31:0] m_wdata;
  logic [31:0]      m_rdata;
  logic             data_req;
  logic             data_gnt;
  logic             data_rvalid;
  logic [31:0]      data_addr;
  logic             data_we;
  logic [3:0]       data_be;
  logic [31:0]      data_wdata;
  logic [31:0]      data_rdata;
  logic             err;

  int total = 0;
  int bad   = 0;

  data_mem_arbiter #(.DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid),
    .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
    .m_rdata_o(m_rdata),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
    .data_addr_o(data_addr), .data_we_o(data_we), .data_be_o(data_be),
    .data_wdata_o(data_wdata), .data_rdata_i(data_rdata), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // One cycle: drive, check mid-cycle, advance past the next rising edge.
  task automatic cyc(input string tag, input logic [1:0] req, input logic gnt,
                     input logic rv, input logic [31:0] rdata,
                     input logic e_req, input logic [1:0] e_gnt,
                     input logic [1:0] e_rv, input logic e_err,
                     input logic [31:0] e_addr);
    m_req = req; data_gnt = gnt; data_rvalid = rv; data_rdata = rdata;
    @(negedge clk);
    chk({tag, ".data_req"}, 32'(data_req), 32'(e_req));
    chk({tag, ".m_gnt"},    32'(m_gnt),    32'(e_gnt));
    chk({tag, ".m_rvalid"}, 32'(m_rvalid), 32'(e_rv));
    chk({tag, ".err"},      32'(err),      32'(e_err));
    chk({tag, ".rdata"},    m_rdata,       rdata);
    if (e_req) chk({tag, ".addr"}, data_addr, e_addr);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; m_req = '0; data_gnt = 1'b0; data_rvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic        e_err;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt [18];

  // Reference model state: owner queue, last winner, hold, sticky error.
  int   mq[$];
  int   m_rr;
  bit   m_lock;
  int   m_owner;
  bit   m_err;

  initial begin
    m_addr  = '0; m_we = '0; m_be = '0; m_wdata = '0; data_rdata = '0;
    m_addr[0] = 32'h200; m_addr[1] = 32'h100;
    rst = 1'b1; m_req = '0; data_gnt = 0; data_rvalid = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    //      req    gnt rv rdata          e_req e_gnt  e_rv  err addr
    vt[0]  = '{2'b00, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 32'h0};
    vt[1]  = '{2'b10, 1, 0, 32'h0,        1, 2'b10, 2'b00, 0, 32'h100};
    vt[2]  = '{2'b00, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 32'h0};
    vt[3]  = '{2'b00, 0, 1, 32'hDEADBEEF, 0, 2'b00, 2'b10, 0, 32'h0};
    vt[4]  = '{2'b11, 1, 0, 32'h0,        1, 2'b01, 2'b00, 0, 32'h200};
    vt[5]  = '{2'b11, 1, 1, 32'h11,       1, 2'b10, 2'b01, 0, 32'h100};
    vt[6]  = '{2'b11, 1, 1, 32'h22,       1, 2'b01, 2'b10, 0, 32'h200};
    vt[7]  = '{2'b11, 1, 1, 32'h33,       1, 2'b10, 2'b01, 0, 32'h100};
    vt[8]  = '{2'b00, 0, 1, 32'h44,       0, 2'b00, 2'b10, 0, 32'h0};
    vt[9]  = '{2'b10, 1, 0, 32'h0,        1, 2'b10, 2'b00, 0, 32'h100};
    vt[10] = '{2'b01, 1, 0, 32'h0,        1, 2'b01, 2'b00, 0, 32'h200};
    vt[11] = '{2'b11, 1, 0, 32'h0,        0, 2'b00, 2'b00, 0, 32'h0};
    vt[12] = '{2'b11, 1, 1, 32'h55,       0, 2'b00, 2'b10, 0, 32'h0};
    vt[13] = '{2'b11, 1, 0, 32'h0,        1, 2'b10, 2'b00, 0, 32'h100};
    vt[14] = '{2'b00, 0, 1, 32'h66,       0, 2'b00, 2'b01, 0, 32'h0};
    vt[15] = '{2'b00, 0, 1, 32'h77,       0, 2'b00, 2'b10, 0, 32'h0};
    vt[16] = '{2'b00, 0, 1, 32'h88,       0, 2'b00, 2'b00, 0, 32'h0};
    vt[17] = '{2'b00, 0, 0, 32'h0,        0, 2'b00, 2'b00, 1, 32'h0};

    for (int i = 0; i < 18; i++) begin
      cyc($sformatf("vec%0d", i), vt[i].req, vt[i].gnt, vt[i].rv, vt[i].rdata,
          vt[i].e_req, vt[i].e_gnt, vt[i].e_rv, vt[i].e_err, vt[i].e_addr);
    end

    // Error stays sticky while idle.
    cyc("sticky0", 2'b00, 0, 0, 32'h0, 0, 2'b00, 2'b00, 1, 32'h0);
    cyc("sticky1", 2'b00, 0, 0, 32'h0, 0, 2'b00, 2'b00, 1, 32'h0);

    // Lock: make m0 the last winner so an unlocked tie would pick m1.
    do_reset();
    cyc("lk_pre",  2'b01, 1, 0, 32'h0, 1, 2'b01, 2'b00, 0, 32'h200);
    cyc("lk_rv",   2'b00, 0, 1, 32'h9, 0, 2'b00, 2'b01, 0, 32'h0);
    cyc("lk_c1",   2'b01, 0, 0, 32'h0, 1, 2'b00, 2'b00, 0, 32'h200);
    cyc("lk_c2",   2'b11, 0, 0, 32'h0, 1, 2'b00, 2'b00, 0, 32'h200);
    cyc("lk_c3",   2'b11, 0, 0, 32'h0, 1, 2'b00, 2'b00, 0, 32'h200);
    cyc("lk_gnt",  2'b11, 1, 0, 32'h0, 1, 2'b01, 2'b00, 0, 32'h200);
    cyc("lk_next", 2'b11, 1, 0, 32'h0, 1, 2'b10, 2'b00, 0, 32'h100);

    // Reset with two outstanding: everything idle, then a stray rvalid.
    do_reset();
    cyc("rs_idle", 2'b00, 0, 0, 32'h0, 0, 2'b00, 2'b00, 0, 32'h0);
    cyc("rs_iss",  2'b10, 1, 0, 32'h0, 1, 2'b10, 2'b00, 0, 32'h100);
    cyc("rs_iss2", 2'b01, 1, 0, 32'h0, 1, 2'b01, 2'b00, 0, 32'h200);
    do_reset();
    cyc("rs_after", 2'b00, 0, 0, 32'h0, 0, 2'b00, 2'b00, 0, 32'h0);
    cyc("rs_stray", 2'b00, 0, 1, 32'h5, 0, 2'b00, 2'b00, 0, 32'h0);
    cyc("rs_err",   2'b00, 0, 0, 32'h0, 0, 2'b00, 2'b00, 1, 32'h0);
    cyc("rs_canreq", 2'b10, 0, 0, 32'h0, 1, 2'b00, 2'b00, 1, 32'h100);

    // Random traffic against the queue-based model.
    do_reset();
    mq.delete(); m_rr = 1; m_lock = 0; m_owner = 0; m_err = 0;
    for (int n = 0; n < 3000; n++) begin
      int win;
      bit e_req;
      logic [1:0] e_gnt, e_rv;
      logic [1:0] req;
      req = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        if (!(m_lock && m_owner == k)) begin
          m_addr[k]  = $urandom; m_wdata[k] = $urandom;
          m_we[k]    = 1'($urandom); m_be[k] = 4'($urandom);
        end
      end
      if (m_lock) req[m_owner] = 1'b1;
      m_req = req;
      data_gnt = ($urandom_range(0, 2) != 0);
      data_rvalid = (mq.size() > 0) ? ($urandom_range(0, 2) == 0)
                                    : ($urandom_range(0, 40) == 0);
      data_rdata = $urandom;

      if (m_lock)           win = m_owner;
      else if (req == 2'b11) win = 1 - m_rr;
      else                   win = req[1] ? 1 : 0;
      e_req = req[win] && (mq.size() < MAXO);
      e_gnt = (e_req && data_gnt) ? 2'(1 << win) : 2'b00;
      e_rv  = (data_rvalid && mq.size() > 0) ? 2'(1 << mq[0]) : 2'b00;

      @(negedge clk);
      chk("rnd.data_req", 32'(data_req), 32'(e_req));
      chk("rnd.m_gnt",    32'(m_gnt),    32'(e_gnt));
      chk("rnd.m_rvalid", 32'(m_rvalid), 32'(e_rv));
      chk("rnd.err",      32'(err),      32'(m_err));
      chk("rnd.rdata",    m_rdata,       data_rdata);
      if (e_req) begin
        chk("rnd.addr",  data_addr,       m_addr[win]);
        chk("rnd.wdata", data_wdata,      m_wdata[win]);
        chk("rnd.we",    32'(data_we),    32'(m_we[win]));
        chk("rnd.be",    32'(data_be),    32'(m_be[win]));
      end

      if (data_rvalid) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_err = 1;
      end
      if (e_req && data_gnt) begin
        mq.push_back(win);
        m_rr = win;
      end
      m_lock  = e_req && !data_gnt;
      m_owner = win;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter that shares the single data-memory port between the MEM-stage load/store unit (master 1) and a secondary requester such as a debug/DMA port (master 0). Uses the core's req/gnt/rvalid memory protocol on every side. Keeps an in-order record of which master owns each outstanding transaction so read responses return to the correct requester. Sits between the load/store unit and the top-level data memory pins.

## Interface
Parameters:
- DATA_WIDTH, 32, address/data width.
- MAX_OUTSTANDING, 2, maximum granted transactions without rvalid (1..8).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- m_req_i  in  [1:0]  per-master request.
- m_gnt_o  out  [1:0]  per-master grant.
- m_rvalid_o  out  [1:0]  per-master response valid.
- m_addr_i  in  2×DATA_WIDTH  per-master address.
- m_we_i  in  [1:0]  per-master write enable.
- m_be_i  in  2×4  per-master byte enables.
- m_wdata_i  in  2×DATA_WIDTH  per-master write data.
- m_rdata_o  out  DATA_WIDTH  shared read data; qualified by m_rvalid_o.
- data_req_o  out  1  memory request.
- data_gnt_i  in  1  memory grant.
- data_rvalid_i  in  1  memory response valid.
- data_addr_o, data_we_o, data_be_o, data_wdata_o  out  DATA_WIDTH/1/4/DATA_WIDTH  muxed request fields.
- data_rdata_i  in  DATA_WIDTH  memory read data.
- err_o  out  1  sticky: rvalid received with no outstanding transaction.

## Operation
- Arbitration: round-robin. rr_last holds the last-granted master. If both masters request, the master other than rr_last wins. rr_last updates only on a completed handshake (data_req_o & data_gnt_i).
- Lock: if data_req_o is high and data_gnt_i is low, the selected master is latched (lock_valid, lock_id). Selection stays fixed until the grant, even if the other master raises req. The locked master must hold req and fields stable (protocol rule; the bench checks it).
- Issue gating: data_req_o = selected m_req & (count < MAX_OUTSTANDING). When count == MAX_OUTSTANDING, no request is issued, even if rvalid arrives in the same cycle.
- m_gnt_o[sel] = data_gnt_i & data_req_o. The other bit is 0.
- ID FIFO: depth MAX_OUTSTANDING, width 1.
  - Push sel on handshake.
  - Pop on data_rvalid_i.
  - count = FIFO occupancy.
- Response routing: m_rvalid_o[head] = data_rvalid_i when count > 0. m_rdata_o = data_rdata_i unconditionally.
- Writes also produce an rvalid and are routed the same way.
- Boundaries:
  - Push and pop in the same cycle: count unchanged; pointers wrap modulo depth.
  - rvalid with count == 0: dropped; err_o set until reset.
  - rvalid and grant for a new transaction in the same cycle: legal; the response belongs to the old head.

## Timing
- Request and grant paths are combinational: zero added latency on req→data_req_o and data_gnt_i→m_gnt_o.
- rvalid→m_rvalid_o is combinational from the FIFO head.
- State registers: rr_last, lock_valid, lock_id, FIFO pointers, count, err.
- Synchronous reset values:
  - rr_last = 1, so master 0 wins the first tie.
  - lock_valid = 0; count = 0; pointers = 0; err_o = 0.
- All outputs derive from these. With inputs idle after reset, data_req_o = 0, m_gnt_o = 0, m_rvalid_o = 0.
- Reset mid-transaction: outstanding IDs are discarded. A later stray rvalid sets err_o.
- No combinational path from data_rvalid_i to data_req_o.

## Structure
- Shared package riscv_cpu_pkg gets:
  - NUM_DMEM_MASTERS = 2.
  - dmem_master_e (DMEM_DBG = 0, DMEM_LSU = 1).
  - dmem_req_t struct {addr, we, be, wdata} used for the per-master request bundles.
- One sub-module: dmem_id_fifo, a parameterised synchronous FIFO with push/pop/count/head.

## Test plan
- Reset, then master 1 reads addr 0x100 with data_gnt_i = 1 the same cycle and rvalid 2 cycles later with rdata 0xDEADBEEF → m_gnt_o = 2'b10 at the handshake; m_rvalid_o = 2'b10 two cycles later with m_rdata_o = 0xDEADBEEF.
- Both masters request continuously with gnt always 1 → grants alternate m0, m1, m0, m1, with m0 first after reset.
- Master 0 requests with gnt low for 3 cycles; master 1 raises req in cycle 2 → data_addr_o stays master 0's address until the grant; master 1 is granted next.
- MAX_OUTSTANDING = 2: grants for m1, then m0, with no rvalid → third request sees data_req_o = 0. Two rvalids route to m1 then m0. data_req_o reasserts the cycle after the first rvalid.
- data_rvalid_i pulse with count = 0 → no m_rvalid_o; err_o = 1 and stays high until rst_i.
- Assert rst_i with 2 transactions outstanding → count = 0 and all outputs at reset values next cycle. A following rvalid sets err_o.
